// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int BLOCK_W         = 128;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int WORD_W          = 32;
  localparam int OFF_W           = 2;
  localparam int MEM_ADDR_W      = 28;

  typedef logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] block_t;

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for dcache_ctrl: valid/dirty/tag/data arrays with a combinational
// read port, a single-word write port and a whole-block fill port, all at one index.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_W      = $clog2(NUM_BLOCKS),
  parameter int TAG_W      = MEM_ADDR_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output block_t            rd_data,
  input  logic              wr_en,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  block_t            fill_data,
  input  logic              clean_en
);

  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [TAG_W-1:0]      tags  [NUM_BLOCKS];
  block_t                blocks[NUM_BLOCKS];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = blocks[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty[idx] <= 1'b1;
    end else if (clean_en) begin
      dirty[idx] <= 1'b0;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[idx]   <= fill_tag;
      blocks[idx] <= fill_data;
    end else if (wr_en) begin
      blocks[idx][wr_off] <= wr_word;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller for the MEM stage.
// Optional DCACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [29:0]           proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  proc_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0]    mem_wdata,
  input  logic [BLOCK_W-1:0]    mem_rdata,
  input  logic                  mem_ready
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;

  state_t state, state_nxt;

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             req;
  logic             hit;
  logic             line_valid;
  logic             line_dirty;
  logic [TAG_W-1:0] line_tag;
  block_t           line_data;
  logic             wr_en;
  logic             fill_en;
  logic             clean_en;

  assign offset = proc_addr[OFF_W-1:0];
  assign index  = proc_addr[IDX_W+1:2];
  assign tag    = proc_addr[29:IDX_W+2];
  assign req    = proc_read | proc_write;
  assign hit    = req & line_valid & (line_tag == tag);

  dcache_line_store #(
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_line_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (index),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (wr_en),
    .wr_off   (offset),
    .wr_word  (proc_wdata),
    .fill_en  (fill_en),
    .fill_tag (tag),
    .fill_data(mem_rdata),
    .clean_en (clean_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The request is held by the stalled pipeline, so the index and address come
  // straight from proc_addr in every state rather than from a latched copy.
  always_comb begin
    state_nxt  = state;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
    clean_en   = 1'b0;
    case (state)
      IDLE: begin
        proc_stall = req & ~hit;
        wr_en      = proc_write & hit;
        if (proc_read && hit) proc_rdata = line_data[offset];
        if (req && !hit) state_nxt = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {line_tag, index};
        mem_wdata  = line_data;
        if (mem_ready) begin
          clean_en  = 1'b1;
          state_nxt = ALLOCATE;
        end
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) begin
          fill_en   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE) begin
      if (hit && hit_cnt != 32'hFFFF_FFFF)               hit_cnt  <= hit_cnt + 32'd1;
      if (req && !hit && miss_cnt != 32'hFFFF_FFFF)      miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: transaction-level cache/memory model plus
// directed scenarios with hand-computed expectations.
module tb_dcache_ctrl;

  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(.NUM_BLOCKS(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .proc_read (proc_read),
    .proc_write(proc_write),
    .proc_addr (proc_addr),
    .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata),
    .proc_stall(proc_stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [127:0] default_block(input logic [27:0] blk);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = {blk, 4'(k)};
    return r;
  endfunction

  // Memory model: blocks written back are remembered, others follow a pattern.
  logic [127:0] mem_blocks [logic [27:0]];
  int           mem_latency = 3;
  int           busy_cnt    = 0;
  bit           force_ready = 1'b0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (!rst_n) busy_cnt = 0;
      else if (mem_read || mem_write) begin
        busy_cnt++;
        if (busy_cnt >= mem_latency) begin
          busy_cnt  = 0;
          mem_ready = 1'b1;
          if (mem_write) mem_blocks[mem_addr] = mem_wdata;
          else mem_rdata = mem_blocks.exists(mem_addr) ? mem_blocks[mem_addr] : default_block(mem_addr);
        end
      end else busy_cnt = 0;
      if (force_ready) begin
        mem_ready   = 1'b1;
        mem_rdata   = {4{32'hBADC0FFE}};
        force_ready = 1'b0;
      end
    end
  end

  // Cache model: lines identified by full block address; a miss is a pending
  // transaction that first writes back (if dirty) and then fetches.
  logic         m_valid[NB];
  logic         m_dirty[NB];
  logic [27:0]  m_blk  [NB];
  logic [127:0] m_data [NB];
  int           m_phase;
  int           m_hits, m_misses;

  function automatic int idx_of(input logic [29:0] a);
    return int'(a[29:2]) % NB;
  endfunction

  function automatic logic model_hit(input logic [29:0] a, input logic req);
    int i = idx_of(a);
    return req && m_valid[i] && (m_blk[i] == a[29:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_phase  = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();

  int   u_i;
  logic u_req;
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else begin
      u_i   = idx_of(proc_addr);
      u_req = proc_read | proc_write;
      case (m_phase)
        0: if (model_hit(proc_addr, u_req)) begin
             m_hits++;
             if (proc_write) begin
               m_data[u_i][proc_addr[1:0]*32 +: 32] = proc_wdata;
               m_dirty[u_i] = 1'b1;
             end
           end else if (u_req) begin
             m_misses++;
             m_phase = (m_valid[u_i] && m_dirty[u_i]) ? 1 : 2;
           end
        1: if (mem_ready) begin
             m_dirty[u_i] = 1'b0;
             m_phase = 2;
           end
        default: if (mem_ready) begin
             m_data[u_i]  = mem_rdata;
             m_blk[u_i]   = proc_addr[29:2];
             m_valid[u_i] = 1'b1;
             m_dirty[u_i] = 1'b0;
             m_phase = 0;
           end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  int   c_i;
  logic c_req, c_hit;
  always @(negedge clk) begin
    if (rst_n) begin
      c_i   = idx_of(proc_addr);
      c_req = proc_read | proc_write;
      c_hit = model_hit(proc_addr, c_req);
      case (m_phase)
        0: begin
          checkOutput("idle_stall", proc_stall, c_req && !c_hit);
          checkOutput("idle_rdata", proc_rdata, (proc_read && c_hit) ? m_data[c_i][proc_addr[1:0]*32 +: 32] : 32'h0);
          checkOutput("idle_mem_read", mem_read, 0);
          checkOutput("idle_mem_write", mem_write, 0);
          checkOutput("idle_mem_addr", mem_addr, 0);
          checkOutput("idle_mem_wdata", mem_wdata, 0);
        end
        1: begin
          checkOutput("wb_stall", proc_stall, 1);
          checkOutput("wb_mem_read", mem_read, 0);
          checkOutput("wb_mem_write", mem_write, 1);
          checkOutput("wb_mem_addr", mem_addr, m_blk[c_i]);
          checkOutput("wb_mem_wdata", mem_wdata, m_data[c_i]);
        end
        default: begin
          checkOutput("alloc_stall", proc_stall, 1);
          checkOutput("alloc_mem_read", mem_read, 1);
          checkOutput("alloc_mem_write", mem_write, 0);
          checkOutput("alloc_mem_addr", mem_addr, proc_addr[29:2]);
        end
      endcase
`ifdef DCACHE_PERF_CNT_EN
      checkOutput("hit_cnt", hit_cnt, m_hits);
      checkOutput("miss_cnt", miss_cnt, m_misses);
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    proc_read  = r;
    proc_write = w;
    proc_addr  = a;
    proc_wdata = d;
  endtask

  // Observations captured while a request is outstanding.
  logic         cap_done, cap_seen_mr, cap_seen_mw, cap_both, cap_addr_changed;
  logic [27:0]  cap_mr_addr, cap_mw_addr;
  logic [127:0] cap_mw_wdata;
  logic [31:0]  cap_rdata;
  int           st;

  task automatic run_request(input logic r, input logic w, input logic [29:0] a,
                             input logic [31:0] d, output int stalls);
    applyStimulus(r, w, a, d);
    stalls = 0;
    cap_done = 0; cap_seen_mr = 0; cap_seen_mw = 0; cap_both = 0; cap_addr_changed = 0;
    cap_mr_addr = '0; cap_mw_addr = '0; cap_mw_wdata = '0; cap_rdata = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (mem_read && mem_write) cap_both = 1;
      if (mem_write && !cap_seen_mw) begin
        cap_seen_mw  = 1;
        cap_mw_addr  = mem_addr;
        cap_mw_wdata = mem_wdata;
      end
      if (mem_read) begin
        if (cap_seen_mr && mem_addr != cap_mr_addr) cap_addr_changed = 1;
        if (!cap_seen_mr) cap_mr_addr = mem_addr;
        cap_seen_mr = 1;
      end
      if (!proc_stall) begin
        cap_done  = 1;
        cap_rdata = proc_rdata;
        break;
      end
      stalls++;
    end
    checkOutput("request_completed", cap_done, 1);
  endtask

  logic saw_mr;

  initial begin
    rst_n = 1'b0;
    proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
    mem_blocks[28'h1] = 128'h44444444_33333333_22222222_11111111;
    #12;
    checkOutput("reset_mem_read", mem_read, 0);
    checkOutput("reset_mem_write", mem_write, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_mem_wdata", mem_wdata, 0);
    checkOutput("reset_proc_stall", proc_stall, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] cold read miss");
    run_request(1, 0, 30'h4, 0, st);
    checkOutput("cold_stall_cycles", st, 4);
    checkOutput("cold_mem_read_seen", cap_seen_mr, 1);
    checkOutput("cold_mem_addr", cap_mr_addr, 28'h1);
    checkOutput("cold_no_writeback", cap_seen_mw, 0);
    checkOutput("cold_rdata", cap_rdata, 32'h11111111);

    $display("[TB] write hit");
    run_request(0, 1, 30'h5, 32'hDEADBEEF, st);
    checkOutput("write_hit_stall", st, 0);
    run_request(1, 0, 30'h5, 0, st);
    checkOutput("read5_stall", st, 0);
    checkOutput("read5_rdata", cap_rdata, 32'hDEADBEEF);
    run_request(1, 0, 30'h4, 0, st);
    checkOutput("read4_rdata", cap_rdata, 32'h11111111);
    applyStimulus(0, 0, 30'h0, 0);
    @(negedge clk);
    #1;
`ifdef DCACHE_PERF_CNT_EN
    checkOutput("perf_hit_cnt", hit_cnt, 32'd4);
    checkOutput("perf_miss_cnt", miss_cnt, 32'd1);
`endif

    $display("[TB] dirty conflict");
    run_request(1, 0, 30'h24, 0, st);
    checkOutput("dirty_stall_cycles", st, 7);
    checkOutput("dirty_wb_seen", cap_seen_mw, 1);
    checkOutput("dirty_wb_addr", cap_mw_addr, 28'h1);
    checkOutput("dirty_wb_word1", cap_mw_wdata[63:32], 32'hDEADBEEF);
    checkOutput("dirty_fetch_addr", cap_mr_addr, 28'h9);
    checkOutput("dirty_never_both", cap_both, 0);
    checkOutput("dirty_rdata", cap_rdata, 32'h00000090);
    run_request(1, 0, 30'h5, 0, st);
    checkOutput("refetch_stall_cycles", st, 4);
    checkOutput("refetch_no_writeback", cap_seen_mw, 0);
    checkOutput("refetch_rdata", cap_rdata, 32'hDEADBEEF);

    $display("[TB] long latency");
    mem_latency = 20;
    run_request(1, 0, 30'h8, 0, st);
    checkOutput("long_stall_cycles", st, 21);
    checkOutput("long_addr_stable", cap_addr_changed, 0);
    checkOutput("long_fetch_addr", cap_mr_addr, 28'h2);
    checkOutput("long_rdata", cap_rdata, 32'h00000020);
    mem_latency = 3;

    $display("[TB] mem_ready in idle");
    applyStimulus(0, 0, 30'h0, 0);
    force_ready = 1'b1;
    repeat (2) @(posedge clk);
    force_ready = 1'b1;
    repeat (2) @(posedge clk);
    run_request(1, 0, 30'h8, 0, st);
    checkOutput("idle_ready_no_stall", st, 0);
    checkOutput("idle_ready_rdata", cap_rdata, 32'h00000020);

    $display("[TB] reset mid-allocate");
    mem_latency = 10;
    applyStimulus(1, 0, 30'hC, 0);
    saw_mr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (mem_read) begin
        saw_mr = 1;
        break;
      end
    end
    checkOutput("abort_mem_read_seen", saw_mr, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_mem_read_async", mem_read, 0);
    checkOutput("abort_mem_write_async", mem_write, 0);
    proc_read = 0;
    mem_latency = 3;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_request(1, 0, 30'h4, 0, st);
    checkOutput("post_reset_miss_stall", st, 4);
    checkOutput("post_reset_fetch_addr", cap_mr_addr, 28'h1);
    checkOutput("post_reset_rdata", cap_rdata, 32'h11111111);

    applyStimulus(0, 0, 30'h0, 0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache in the MEM stage of the 5-stage MIPS pipeline, between EX_MEM_reg (address and store data) and MEM_WB_reg (load data). On a miss it drives `proc_stall`, which freezes every pipeline register, and it runs a block-granular handshake with main memory. Hits complete combinationally in the same cycle with no stall.

## Interface
- `NUM_BLOCKS`, default 8. Number of cache lines; must be a power of 2, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `proc_read`  in  1  load request (ALU result valid as address).
- `proc_write`  in  1  store request.
- `proc_addr`  in  30  word address; byte address[31:2].
- `proc_wdata`  in  32  store data.
- `proc_rdata`  out  32  load data; valid when `proc_read` is high and `proc_stall` is low.
- `proc_stall`  out  1  pipeline freeze.
- `mem_read`  out  1  block fetch request.
- `mem_write`  out  1  block writeback request.
- `mem_addr`  out  28  block address (word address[29:2]).
- `mem_wdata`  out  128  victim block; word 0 in bits [31:0].
- `mem_rdata`  in  128  fetched block; same packing as `mem_wdata`.
- `mem_ready`  in  1  one-cycle pulse: the request is complete, and for a read `mem_rdata` is valid.

## Operation
- Address split with IDX_W = log2(NUM_BLOCKS):
  - offset = `proc_addr[1:0]`
  - index = `proc_addr[IDX_W+1:2]`
  - tag = `proc_addr[29:IDX_W+2]`
- Each line holds valid, dirty, tag and 4×32 data.
- hit = req & valid[index] & (tag match), where req = `proc_read` | `proc_write`. If both `proc_read` and `proc_write` are high, the request is treated as a write.
- States:
  - IDLE
    - Read hit: `proc_rdata` = selected word.
    - Write hit: at the clock edge, write the word and set dirty.
    - Miss on a dirty line: go to WRITEBACK.
    - Miss on a clean or invalid line: go to ALLOCATE.
    - No request: stay in IDLE.
  - WRITEBACK
    - `mem_write`=1, `mem_addr`={victim tag, index}, `mem_wdata`=line data.
    - On `mem_ready`: clear dirty and go to ALLOCATE.
  - ALLOCATE
    - `mem_read`=1, `mem_addr`=`proc_addr[29:2]`.
    - On `mem_ready`: load `mem_rdata`, set valid, set tag, clear dirty, go to IDLE. The request then hits in IDLE, and a pending write merges there.
- `proc_stall` = (req & ~hit) in IDLE, and 1 in WRITEBACK and ALLOCATE.
- `mem_read` and `mem_write` are never high together, and are 0 in IDLE.
- `mem_addr` and `mem_wdata` are stable while a request is high. They are 0 in IDLE.
- `proc_rdata` is 0 when there is no read hit.

## Timing
- Reset values:
  - all valid and dirty bits = 0, state = IDLE
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata` = 0
  - `proc_stall` = 0 while req = 0
  - data and tag arrays are not reset
- Hit latency is 0 cycles and there is no stall.
- Clean miss: N+1 cycles of stall, where N is the number of cycles from `mem_read` rising to `mem_ready`. `mem_read` rises in the cycle after the miss is detected. The hit data appears in the cycle after `mem_ready`.
- Dirty miss: the writeback latency is added to the clean-miss latency. `mem_write` drops and `mem_read` rises in the cycle after `mem_ready`.
- `mem_ready` is sampled only in WRITEBACK and ALLOCATE. In IDLE it is ignored.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE:
  - `mem_read` and `mem_write` drop immediately (asynchronously).
  - The line is left invalid.
  - The memory model must tolerate the aborted request.
- Inputs are held stable by the stalled pipeline throughout a miss. The block does not latch the request.

## Configuration
- Macro `DCACHE_PERF_CNT_EN`, when defined:
  - Adds outputs `hit_cnt[31:0]` and `miss_cnt[31:0]`, both reset to 0.
  - `hit_cnt` increments on every non-stalled hit edge.
  - `miss_cnt` increments once per miss, on the IDLE→WRITEBACK or IDLE→ALLOCATE transition.
  - Both counters saturate at 32'hFFFF_FFFF.
- When not defined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `dcache_pkg` holds:
  - the state encoding (IDLE=2'd0, WRITEBACK=2'd1, ALLOCATE=2'd2)
  - the block width constant (128)
  - the words-per-block constant (4)
- Sub-module `dcache_line_store` holds the valid/dirty/tag/data arrays:
  - combinational read port by index
  - one word-write port
  - one block-fill port
- `dcache_ctrl` holds the FSM, hit logic and memory handshake.

## Test plan
- **Cold read miss.** After reset, read `proc_addr`=30'h4 (index 1, offset 0).
  - `proc_stall`=1 and `mem_read`=1 with `mem_addr`=28'h1.
  - Memory returns 128'h44444444_33333333_22222222_11111111 with `mem_ready` after 3 cycles.
  - In the next cycle `proc_rdata`=32'h11111111 and `proc_stall`=0.
- **Write hit.** Write 32'hDEADBEEF to 30'h5.
  - No stall.
  - Reading 30'h5 returns DEADBEEF and reading 30'h4 returns 11111111.
- **Dirty conflict.** Read 30'h24 (same index, tag 1).
  - First `mem_write`=1 with `mem_addr`=28'h1 and `mem_wdata`[63:32]=DEADBEEF.
  - After `mem_ready`, `mem_read` with `mem_addr`=28'h9.
  - `mem_read` and `mem_write` are never high together.
- **Long latency.** Hold `mem_ready` low for 20 cycles.
  - `mem_read` and `mem_addr` stay stable and `proc_stall` stays high every cycle.
  - `mem_ready` pulses while in IDLE are ignored.
- **Reset mid-ALLOCATE.** Pull `rst_n` low while `mem_read`=1.
  - `mem_read` drops without waiting for a clock.
  - After release, reading 30'h4 misses again.
- **Performance counters (`DCACHE_PERF_CNT_EN` defined).** After scenarios 1–2: `hit_cnt`=4 and `miss_cnt`=1.
